// File: rtl/tea_iter_core_if.sv
// Block-in / result-out valid/ready bundle for tea_iter_core.
// The slave modport is the core; the master modport is the source/sink side.
interface tea_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic [63:0]  in_v;
  logic [127:0] in_k;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_v;
  logic         out_decrypt;

  modport master (
    output in_valid, in_decrypt, in_v, in_k, out_ready,
    input  in_ready, out_valid, out_v, out_decrypt
  );

  modport slave (
    input  in_valid, in_decrypt, in_v, in_k, out_ready,
    output in_ready, out_valid, out_v, out_decrypt
  );
endinterface

// File: rtl/tea_iter_core.sv
// Iterative TEA encrypt/decrypt engine: ROUNDS TEA cycles per block,
// UNROLL of them chained combinationally per clock, valid/ready on both sides.
module tea_iter_core #(
  parameter int ROUNDS = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  tea_iter_core_if.slave   bus
);

  localparam logic [31:0] DELTA        = 32'h9E3779B9;
  localparam int          STEPS        = ROUNDS / UNROLL;
  localparam int          CNT_W        = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [31:0] SUM_DEC_INIT = 32'(ROUNDS) * DELTA;

  if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_cfg
    $error("tea_iter_core: ROUNDS must be >= 1 and UNROLL must divide ROUNDS");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q, state_d;
  logic [31:0]  v0_q, v1_q, sum_q;
  logic [127:0] k_q;
  logic         dec_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]  out_v_q;
  logic         out_dec_q;

  logic [31:0]  v0_n, v1_n, sum_n;
  logic         in_rdy;
  logic         accept;
  logic         last_step;

  function automatic logic [31:0] tea_f(input logic [31:0] x,
                                        input logic [63:0] kp,
                                        input logic [31:0] s);
    return ((x << 4) + kp[63:32]) ^ (x + s) ^ ((x >> 5) + kp[31:0]);
  endfunction

  // NOTE: blocking assignments here chain the UNROLL cycles inside one clock;
  // every register below is updated only with non-blocking assignments.
  always_comb begin
    v0_n  = v0_q;
    v1_n  = v1_q;
    sum_n = sum_q;
    for (int i = 0; i < UNROLL; i++) begin
      if (dec_q) begin
        v1_n  = v1_n - tea_f(v0_n, k_q[127:64], sum_n);
        v0_n  = v0_n - tea_f(v1_n, k_q[63:0], sum_n);
        sum_n = sum_n - DELTA;
      end else begin
        sum_n = sum_n + DELTA;
        v0_n  = v0_n + tea_f(v1_n, k_q[63:0], sum_n);
        v1_n  = v1_n + tea_f(v0_n, k_q[127:64], sum_n);
      end
    end
  end

  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

  // NOTE: every output of this block gets a default first, so no latches form.
  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          in_rdy  = 1'b1;
          state_d = bus.in_valid ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept          = bus.in_valid & in_rdy;
  assign bus.in_ready    = in_rdy & ~rst;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_v       = out_v_q;
  assign bus.out_decrypt = out_dec_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      v0_q      <= '0;
      v1_q      <= '0;
      sum_q     <= '0;
      k_q       <= '0;
      dec_q     <= 1'b0;
      cnt_q     <= '0;
      out_v_q   <= '0;
      out_dec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        v0_q  <= bus.in_v[63:32];
        v1_q  <= bus.in_v[31:0];
        k_q   <= bus.in_k;
        dec_q <= bus.in_decrypt;
        sum_q <= bus.in_decrypt ? SUM_DEC_INIT : 32'h0;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        v0_q  <= v0_n;
        v1_q  <= v1_n;
        sum_q <= sum_n;
        cnt_q <= cnt_q + 1'b1;
        // Result lands in out_v on the same edge the FSM enters DONE.
        if (last_step) begin
          out_v_q   <= {v0_n, v1_n};
          out_dec_q <= dec_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_tea_iter_core.sv
// Self-checking bench for tea_iter_core: algorithmic TEA model + scoreboard on
// the default instance, plus small directed runs on several ROUNDS/UNROLL builds.
module tb_tea_iter_core;

  localparam logic [31:0] DELTA      = 32'h9E3779B9;
  localparam int          MAIN_R     = 32;
  localparam int          MAIN_U     = 1;
  localparam int          MAIN_STEPS = MAIN_R / MAIN_U;
  localparam int          NCFG       = 6;
  localparam int          CFG_R [NCFG] = '{32, 64, 8, 1, 32, 8};
  localparam int          CFG_U [NCFG] = '{4, 8, 2, 1, 32, 8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cfg_done_cnt = 0;
  bit reset_done = 1'b0;

  tea_iter_core_if bus ();

  tea_iter_core #(.ROUNDS(MAIN_R), .UNROLL(MAIN_U)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic mark_cfg_done();
    cfg_done_cnt++;
  endtask

  // Reference TEA straight from the algorithm description, one cycle at a time.
  function automatic logic [31:0] tea_rf(input logic [31:0] x, input logic [63:0] kp,
                                         input logic [31:0] s);
    return ((x << 4) + kp[63:32]) ^ (x + s) ^ ((x >> 5) + kp[31:0]);
  endfunction

  function automatic logic [63:0] tea_model(input logic [63:0] v, input logic [127:0] k,
                                            input logic dec, input int rounds);
    logic [31:0] y, z, s;
    y = v[63:32];
    z = v[31:0];
    s = dec ? 32'(rounds) * DELTA : 32'h0;
    for (int r = 0; r < rounds; r++) begin
      if (!dec) begin
        s = s + DELTA;
        y = y + tea_rf(z, k[63:0], s);
        z = z + tea_rf(y, k[127:64], s);
      end else begin
        z = z - tea_rf(y, k[127:64], s);
        y = y - tea_rf(z, k[63:0], s);
        s = s - DELTA;
      end
    end
    return {y, z};
  endfunction

  // Scoreboard: samples one time unit before each rising edge.
  typedef struct {
    logic [63:0] v;
    logic        dec;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  logic        held_prev = 1'b0;
  logic [63:0] prev_v = '0;

  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      exp_q.delete();
      held_prev = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        check("no_unexpected_valid", bus.out_valid, 1'b0);
      end else if (bus.out_valid) begin
        check("sb_out_v", bus.out_v, exp_q[0].v);
        check("sb_out_decrypt", bus.out_decrypt, exp_q[0].dec);
        if (!held_prev) check("sb_latency", 128'((cyc - 1) - exp_q[0].acc), 128'(MAIN_STEPS));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
      if (held_prev) check("sb_hold_stable", bus.out_v, prev_v);
      if (bus.out_valid && !bus.out_ready) check("sb_hold_in_ready", bus.in_ready, 1'b0);
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back('{v: tea_model(bus.in_v, bus.in_k, bus.in_decrypt, MAIN_R),
                          dec: bus.in_decrypt, acc: cyc});
      held_prev = bus.out_valid && !bus.out_ready;
      prev_v    = bus.out_v;
    end
    cyc++;
  end

  task automatic start(input logic [63:0] v, input logic [127:0] k, input logic dec);
    bit ok = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_v       = v;
    bus.in_k       = k;
    bus.in_decrypt = dec;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    check("start_accept", ok, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid while scrambling in_* so only captured values matter.
  task automatic wait_done(output logic [63:0] res);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
      else begin
        bus.in_v       = {$urandom, $urandom};
        bus.in_k       = {$urandom, $urandom, $urandom, $urandom};
        bus.in_decrypt = 1'($urandom_range(0, 1));
      end
    end
    check("done_timeout", ok, 1'b1);
    res = bus.out_v;
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic watch_no_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= bus.out_valid;
    end
    check(name, seen, 1'b0);
  endtask

  initial begin : main_flow
    logic [63:0]  p, c, r, p2;
    logic [127:0] k, k2;
    bus.in_valid = 1'b0; bus.in_v = '0; bus.in_k = '0; bus.in_decrypt = 1'b0;
    bus.out_ready = 1'b0;

    // Literal pins on the model itself.
    check("model_enc_zero", tea_model(64'h0, 128'h0, 1'b0, 32), 64'h41EA3A0A_94BAA940);
    check("model_dec_zero", tea_model(64'h41EA3A0A_94BAA940, 128'h0, 1'b1, 32), 64'h0);
    check("model_enc_1round", tea_model(64'h0, 128'h0, 1'b0, 1), 64'h9E3779B9_DBE8D32F);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_done = 1'b1;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_out_v", bus.out_v, 64'h0);
    check("reset_out_decrypt", bus.out_decrypt, 1'b0);
    @(posedge clk);
    #1;

    start(64'h0, 128'h0, 1'b0);
    wait_done(r);
    check("enc_zero_out_v", r, 64'h41EA3A0A_94BAA940);
    check("enc_zero_decrypt", bus.out_decrypt, 1'b0);
    retire();

    start(64'h41EA3A0A_94BAA940, 128'h0, 1'b1);
    wait_done(r);
    check("dec_zero_out_v", r, 64'h0);
    check("dec_zero_decrypt", bus.out_decrypt, 1'b1);
    retire();

    for (int n = 0; n < 300; n++) begin
      p = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      start(p, k, 1'b0);
      wait_done(c);
      retire();
      start(c, k, 1'b1);
      wait_done(p2);
      retire();
      check("roundtrip", p2, p);
    end

    // Backpressure, then release with a waiting request: no IDLE bubble.
    p  = 64'h01234567_89ABCDEF;
    k  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    p2 = 64'hFEDCBA98_76543210;
    k2 = 128'hDEADBEEF_01020304_A5A5A5A5_5A5A5A5A;
    start(p, k, 1'b0);
    wait_done(r);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_v_stable", bus.out_v, r);
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_in_ready_low", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b1; bus.in_v = p2; bus.in_k = k2; bus.in_decrypt = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    wait_done(r);
    check("bp_next_out_v", r, tea_model(p2, k2, 1'b0, MAIN_R));
    retire();

    // Side instances must be finished before the shared reset is pulsed.
    for (int i = 0; i < 5000 && cfg_done_cnt < NCFG; i++) @(posedge clk);
    check("cfg_runs_done", 128'(cfg_done_cnt), 128'(NCFG));
    #1;

    // Reset while RUN with the counter at 15.
    start(p, k, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_run_in_ready", bus.in_ready, 1'b1);
    check("rst_run_out_valid", bus.out_valid, 1'b0);
    watch_no_valid("rst_run_no_valid");
    @(posedge clk);
    #1;
    start(p2, k2, 1'b1);
    wait_done(r);
    check("after_rst_run_out_v", r, tea_model(p2, k2, 1'b1, MAIN_R));
    retire();

    // Reset in DONE with a pending result.
    start(p, k2, 1'b0);
    wait_done(r);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_done_in_ready", bus.in_ready, 1'b1);
    check("rst_done_out_valid", bus.out_valid, 1'b0);
    watch_no_valid("rst_done_no_valid");
    @(posedge clk);
    #1;
    start(p2, k, 1'b0);
    wait_done(r);
    check("after_rst_done_out_v", r, tea_model(p2, k, 1'b0, MAIN_R));
    retire();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #900000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Extra ROUNDS/UNROLL builds: directed result and latency checks.
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int R = CFG_R[g];
    localparam int U = CFG_U[g];

    tea_iter_core_if bus_g ();

    tea_iter_core #(.ROUNDS(R), .UNROLL(U)) dut_g (
      .clk (clk),
      .rst (rst),
      .bus (bus_g.slave)
    );

    initial begin : drv
      logic [63:0]  v, r;
      logic [127:0] k;
      logic         dec;
      int           lat;
      bus_g.in_valid = 1'b0; bus_g.in_v = '0; bus_g.in_k = '0; bus_g.in_decrypt = 1'b0;
      bus_g.out_ready = 1'b1;
      wait (reset_done);
      for (int t = 0; t < 4; t++) begin
        v   = (t == 0) ? 64'h0  : {$urandom, $urandom};
        k   = (t == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
        dec = (t % 2) == 1;
        @(posedge clk);
        #1;
        bus_g.in_valid = 1'b1; bus_g.in_v = v; bus_g.in_k = k; bus_g.in_decrypt = dec;
        @(negedge clk);
        check($sformatf("cfg%0d_in_ready", g), bus_g.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus_g.in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 200 && !bus_g.out_valid; i++) begin
          @(posedge clk);
          #1;
          lat++;
        end
        check($sformatf("cfg%0d_latency", g), 128'(lat), 128'(R / U));
        check($sformatf("cfg%0d_out_v", g), bus_g.out_v, tea_model(v, k, dec, R));
        check($sformatf("cfg%0d_out_decrypt", g), bus_g.out_decrypt, dec);
      end
      mark_cfg_done();
    end
  end

endmodule
